// File: rtl/dfi_phy_hs_responder.sv
// PHY-side DFI handshake responder: LP ctrl/data, ctrlupd and phyupd handshakes.
// Optional feature: define DFI_PHY_RESP_PHYUPD_TIMEOUT_EN to enable the phyupd ack timeout.
module dfi_phy_hs_responder #(
  parameter int unsigned LP_ACK_DLY      = 2,
  parameter int unsigned CTRLUPD_ACK_DLY = 1,
  parameter int unsigned PHYUPD_HOLD     = 4,
  parameter int unsigned TPHYUPD_RESP    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       lp_ctrl_req,
  input  logic       lp_data_req,
  input  logic [5:0] lp_ctrl_wakeup,
  input  logic [5:0] lp_data_wakeup,
  input  logic [1:0] lp_accept,
  output logic       lp_ctrl_ack,
  output logic       lp_data_ack,
  output logic [5:0] lp_ctrl_wakeup_q,
  output logic [5:0] lp_data_wakeup_q,
  input  logic       ctrlupd_req,
  output logic       ctrlupd_ack,
  input  logic       phyupd_start,
  input  logic [1:0] phyupd_type_in,
  output logic       phyupd_req,
  output logic [1:0] phyupd_type,
  input  logic       phyupd_ack,
  output logic       phyupd_busy,
  output logic       phyupd_err
);

  typedef enum logic [1:0] {LP_IDLE, LP_WAIT, LP_ACK, LP_REJ} lp_state_e;
  typedef enum logic [1:0] {CU_IDLE, CU_WAIT, CU_ACK} cu_state_e;
  typedef enum logic [1:0] {PU_IDLE, PU_REQ, PU_HOLD, PU_DROP} pu_state_e;

  localparam logic [7:0] LP_LD   = 8'(LP_ACK_DLY);
  localparam logic [7:0] CU_LD   = 8'(CTRLUPD_ACK_DLY);
  localparam logic [7:0] HOLD_LD = 8'(PHYUPD_HOLD);
  localparam logic [7:0] RESP_LD = 8'(TPHYUPD_RESP);

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  // Index 0 is the ctrl channel, index 1 the data channel.
  lp_state_e  lp_state_q [2];
  lp_state_e  lp_state_d [2];
  logic [7:0] lp_cnt_q   [2];
  logic [7:0] lp_cnt_d   [2];
  logic [5:0] lp_wake_q  [2];
  logic [5:0] lp_wake_d  [2];
  logic [5:0] lp_wake_in [2];
  logic [1:0] lp_req;

  assign lp_req        = {lp_data_req, lp_ctrl_req};
  assign lp_wake_in[0] = lp_ctrl_wakeup;
  assign lp_wake_in[1] = lp_data_wakeup;

  // The cycle req is first sampled counts as the first delay cycle, so a delay of 1 acks immediately.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lp_state_d[i] = lp_state_q[i];
      lp_cnt_d[i]   = lp_cnt_q[i];
      lp_wake_d[i]  = lp_wake_q[i];
      case (lp_state_q[i])
        LP_IDLE: begin
          if (lp_req[i]) begin
            if (lp_accept[i]) begin
              lp_wake_d[i]  = lp_wake_in[i];
              lp_cnt_d[i]   = LP_LD;
              lp_state_d[i] = (LP_LD <= 8'd1) ? LP_ACK : LP_WAIT;
            end else begin
              lp_state_d[i] = LP_REJ;
            end
          end
        end
        LP_WAIT: begin
          if (!lp_req[i]) begin
            lp_state_d[i] = LP_IDLE;
            lp_cnt_d[i]   = 8'd0;
          end else begin
            lp_cnt_d[i] = sat_dec(lp_cnt_q[i]);
            if (lp_cnt_q[i] <= 8'd2) lp_state_d[i] = LP_ACK;
          end
        end
        LP_ACK:  if (!lp_req[i]) lp_state_d[i] = LP_IDLE;
        LP_REJ:  if (!lp_req[i]) lp_state_d[i] = LP_IDLE;
        default: lp_state_d[i] = LP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        lp_state_q[i] <= LP_IDLE;
        lp_cnt_q[i]   <= 8'd0;
        lp_wake_q[i]  <= 6'd0;
      end else begin
        lp_state_q[i] <= lp_state_d[i];
        lp_cnt_q[i]   <= lp_cnt_d[i];
        lp_wake_q[i]  <= lp_wake_d[i];
      end
    end
  end

  assign lp_ctrl_ack      = (lp_state_q[0] == LP_ACK);
  assign lp_data_ack      = (lp_state_q[1] == LP_ACK);
  assign lp_ctrl_wakeup_q = lp_wake_q[0];
  assign lp_data_wakeup_q = lp_wake_q[1];

  cu_state_e  cu_state_q, cu_state_d;
  logic [7:0] cu_cnt_q, cu_cnt_d;

  // ctrlupd holds off in IDLE while a phyupd request is on the bus.
  always_comb begin
    cu_state_d = cu_state_q;
    cu_cnt_d   = cu_cnt_q;
    case (cu_state_q)
      CU_IDLE: begin
        if (ctrlupd_req && !phyupd_req) begin
          cu_cnt_d   = CU_LD;
          cu_state_d = (CU_LD <= 8'd1) ? CU_ACK : CU_WAIT;
        end
      end
      CU_WAIT: begin
        if (!ctrlupd_req) begin
          cu_state_d = CU_IDLE;
          cu_cnt_d   = 8'd0;
        end else begin
          cu_cnt_d = sat_dec(cu_cnt_q);
          if (cu_cnt_q <= 8'd2) cu_state_d = CU_ACK;
        end
      end
      CU_ACK:  if (!ctrlupd_req) cu_state_d = CU_IDLE;
      default: cu_state_d = CU_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cu_state_q <= CU_IDLE;
      cu_cnt_q   <= 8'd0;
    end else begin
      cu_state_q <= cu_state_d;
      cu_cnt_q   <= cu_cnt_d;
    end
  end

  assign ctrlupd_ack = (cu_state_q == CU_ACK);

  pu_state_e  pu_state_q, pu_state_d;
  logic [7:0] pu_cnt_q, pu_cnt_d;
  logic       pending_q, pending_d;
  logic [1:0] type_q, type_d;
`ifdef DFI_PHY_RESP_PHYUPD_TIMEOUT_EN
  logic       err_q, err_d;
`endif

  // A start pulse launches in the same edge when ctrlupd is quiet; otherwise it parks in pending.
  always_comb begin
    pu_state_d = pu_state_q;
    pu_cnt_d   = pu_cnt_q;
    pending_d  = pending_q;
    type_d     = type_q;
`ifdef DFI_PHY_RESP_PHYUPD_TIMEOUT_EN
    err_d      = 1'b0;
`endif
    case (pu_state_q)
      PU_IDLE: begin
        if (phyupd_start && !pending_q) type_d = phyupd_type_in;
        if (pending_q || phyupd_start) begin
          if (!ctrlupd_req && !ctrlupd_ack) begin
            pu_state_d = PU_REQ;
            pu_cnt_d   = RESP_LD;
            pending_d  = 1'b0;
          end else begin
            pending_d = 1'b1;
          end
        end
      end
      PU_REQ: begin
        if (phyupd_ack) begin
          pu_cnt_d   = HOLD_LD;
          pu_state_d = (HOLD_LD <= 8'd1) ? PU_DROP : PU_HOLD;
        end
`ifdef DFI_PHY_RESP_PHYUPD_TIMEOUT_EN
        else if (pu_cnt_q <= 8'd1) begin
          pu_state_d = PU_DROP;
          pu_cnt_d   = 8'd0;
          err_d      = 1'b1;
        end else begin
          pu_cnt_d = sat_dec(pu_cnt_q);
        end
`endif
      end
      PU_HOLD: begin
        pu_cnt_d = sat_dec(pu_cnt_q);
        if (pu_cnt_q <= 8'd2) pu_state_d = PU_DROP;
      end
      PU_DROP: if (!phyupd_ack) pu_state_d = PU_IDLE;
      default: pu_state_d = PU_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pu_state_q <= PU_IDLE;
      pu_cnt_q   <= 8'd0;
      pending_q  <= 1'b0;
      type_q     <= 2'd0;
`ifdef DFI_PHY_RESP_PHYUPD_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      pu_state_q <= pu_state_d;
      pu_cnt_q   <= pu_cnt_d;
      pending_q  <= pending_d;
      type_q     <= type_d;
`ifdef DFI_PHY_RESP_PHYUPD_TIMEOUT_EN
      err_q      <= err_d;
`endif
    end
  end

  assign phyupd_req  = (pu_state_q == PU_REQ) || (pu_state_q == PU_HOLD);
  assign phyupd_type = type_q;
  assign phyupd_busy = pending_q || (pu_state_q != PU_IDLE);
`ifdef DFI_PHY_RESP_PHYUPD_TIMEOUT_EN
  assign phyupd_err  = err_q;
`else
  assign phyupd_err  = 1'b0;
`endif

endmodule

// File: tb/tb_dfi_phy_hs_responder.sv
// Self-checking bench for dfi_phy_hs_responder: directed handshake scenarios plus
// randomized LP traffic checked against a run-length reference model.
module tb_dfi_phy_hs_responder;

  localparam int unsigned LP_DLY = 2;
  localparam int unsigned CU_DLY = 1;
  localparam int unsigned HOLD   = 4;
  localparam int unsigned TRESP  = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       lp_ctrl_req, lp_data_req;
  logic [5:0] lp_ctrl_wakeup, lp_data_wakeup;
  logic [1:0] lp_accept;
  logic       lp_ctrl_ack, lp_data_ack;
  logic [5:0] lp_ctrl_wakeup_q, lp_data_wakeup_q;
  logic       ctrlupd_req, ctrlupd_ack;
  logic       phyupd_start;
  logic [1:0] phyupd_type_in;
  logic       phyupd_req;
  logic [1:0] phyupd_type;
  logic       phyupd_ack, phyupd_busy, phyupd_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state: consecutive high cycles of req, accept decision and wakeup captured at run start.
  int         run [2];
  logic       acc [2];
  logic [5:0] wq  [2];
  logic       ackx[2];

  always #5 clock = ~clock;

  dfi_phy_hs_responder #(
    .LP_ACK_DLY(LP_DLY), .CTRLUPD_ACK_DLY(CU_DLY), .PHYUPD_HOLD(HOLD), .TPHYUPD_RESP(TRESP)
  ) dut (
    .clock(clock), .reset(reset),
    .lp_ctrl_req(lp_ctrl_req), .lp_data_req(lp_data_req),
    .lp_ctrl_wakeup(lp_ctrl_wakeup), .lp_data_wakeup(lp_data_wakeup),
    .lp_accept(lp_accept),
    .lp_ctrl_ack(lp_ctrl_ack), .lp_data_ack(lp_data_ack),
    .lp_ctrl_wakeup_q(lp_ctrl_wakeup_q), .lp_data_wakeup_q(lp_data_wakeup_q),
    .ctrlupd_req(ctrlupd_req), .ctrlupd_ack(ctrlupd_ack),
    .phyupd_start(phyupd_start), .phyupd_type_in(phyupd_type_in),
    .phyupd_req(phyupd_req), .phyupd_type(phyupd_type), .phyupd_ack(phyupd_ack),
    .phyupd_busy(phyupd_busy), .phyupd_err(phyupd_err)
  );

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelStep(input logic rst_n, input logic [1:0] req, input logic [1:0] accept,
                           input logic [5:0] wake0, input logic [5:0] wake1);
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        run[c] = 0; acc[c] = 1'b0; wq[c] = 6'd0; ackx[c] = 1'b0;
      end else if (req[c]) begin
        if (run[c] == 0) begin
          acc[c] = accept[c];
          if (accept[c]) wq[c] = (c == 0) ? wake0 : wake1;
        end
        if (run[c] < 1000) run[c]++;
        ackx[c] = acc[c] && (run[c] >= int'(LP_DLY));
      end else begin
        run[c] = 0; ackx[c] = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0;
    lp_ctrl_req = 1'b0; lp_data_req = 1'b0;
    lp_ctrl_wakeup = 6'd0; lp_data_wakeup = 6'd0; lp_accept = 2'b00;
    ctrlupd_req = 1'b0; phyupd_start = 1'b0; phyupd_type_in = 2'b00; phyupd_ack = 1'b0;
    applyStimulus(3);
    checkOutput("rst_lp_ctrl_ack", lp_ctrl_ack, 1'b0);
    checkOutput("rst_lp_data_ack", lp_data_ack, 1'b0);
    checkOutput("rst_ctrlupd_ack", ctrlupd_ack, 1'b0);
    checkOutput("rst_phyupd_req", phyupd_req, 1'b0);
    checkOutput("rst_phyupd_busy", phyupd_busy, 1'b0);
    checkOutput("rst_phyupd_err", phyupd_err, 1'b0);
    reset = 1'b1;
    applyStimulus(2);

    $display("[TB] lp ctrl accepted request");
    lp_accept = 2'b11; lp_ctrl_wakeup = 6'h05; lp_ctrl_req = 1'b1;
    applyStimulus(1);
    checkOutput("lp_ctrl_wait", lp_ctrl_ack, 1'b0);
    applyStimulus(1);
    checkOutput("lp_ctrl_ack_rise", lp_ctrl_ack, 1'b1);
    checkOutput("lp_ctrl_wakeup_q", lp_ctrl_wakeup_q, 6'h05);
    lp_ctrl_wakeup = 6'h2a;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1);
      checkOutput("lp_ctrl_ack_hold", lp_ctrl_ack, 1'b1);
    end
    lp_ctrl_req = 1'b0;
    applyStimulus(1);
    checkOutput("lp_ctrl_ack_fall", lp_ctrl_ack, 1'b0);
    checkOutput("lp_ctrl_wakeup_keep", lp_ctrl_wakeup_q, 6'h05);

    $display("[TB] lp ctrl request dropped while waiting");
    lp_ctrl_req = 1'b1;
    applyStimulus(1);
    lp_ctrl_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("lp_ctrl_wait_drop", lp_ctrl_ack, 1'b0);
    end

    $display("[TB] lp data rejected then accepted");
    lp_accept = 2'b01; lp_data_wakeup = 6'h1f; lp_data_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) lp_accept = 2'b11;
      applyStimulus(1);
      checkOutput("lp_data_rej", lp_data_ack, 1'b0);
    end
    lp_data_req = 1'b0;
    applyStimulus(1);
    checkOutput("lp_data_rej_exit", lp_data_ack, 1'b0);
    lp_accept = 2'b11; lp_data_wakeup = 6'h33; lp_data_req = 1'b1;
    applyStimulus(1);
    checkOutput("lp_data_wait", lp_data_ack, 1'b0);
    applyStimulus(1);
    checkOutput("lp_data_ack_rise", lp_data_ack, 1'b1);
    checkOutput("lp_data_wakeup_q", lp_data_wakeup_q, 6'h33);
    lp_data_req = 1'b0;
    applyStimulus(1);
    checkOutput("lp_data_ack_fall", lp_data_ack, 1'b0);

    $display("[TB] phyupd normal handshake");
    phyupd_start = 1'b1; phyupd_type_in = 2'b01;
    applyStimulus(1);
    phyupd_start = 1'b0; phyupd_type_in = 2'b10;
    checkOutput("pu_req_rise", phyupd_req, 1'b1);
    checkOutput("pu_type", phyupd_type, 2'b01);
    checkOutput("pu_busy", phyupd_busy, 1'b1);
    applyStimulus(2);
    phyupd_ack = 1'b1;
    checkOutput("pu_req_at_ack", phyupd_req, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      phyupd_start = (i == 0);
      checkOutput("pu_req_hold", phyupd_req, 1'b1);
      checkOutput("pu_type_hold", phyupd_type, 2'b01);
    end
    phyupd_start = 1'b0;
    applyStimulus(1);
    checkOutput("pu_req_drop", phyupd_req, 1'b0);
    checkOutput("pu_busy_drop", phyupd_busy, 1'b1);
    checkOutput("pu_type_drop", phyupd_type, 2'b01);
    phyupd_ack = 1'b0;
    applyStimulus(1);
    checkOutput("pu_busy_clear", phyupd_busy, 1'b0);
    applyStimulus(2);
    checkOutput("pu_ignored_start", phyupd_busy, 1'b0);
    checkOutput("pu_ignored_req", phyupd_req, 1'b0);

    $display("[TB] ctrlupd wins against pending phyupd");
    ctrlupd_req = 1'b1; phyupd_start = 1'b1; phyupd_type_in = 2'b11;
    applyStimulus(1);
    phyupd_start = 1'b0;
    checkOutput("cu_ack_rise", ctrlupd_ack, 1'b1);
    checkOutput("cu_pu_req_low", phyupd_req, 1'b0);
    checkOutput("cu_pu_busy", phyupd_busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("cu_pu_wait", phyupd_req, 1'b0);
    end
    ctrlupd_req = 1'b0;
    applyStimulus(1);
    checkOutput("cu_ack_fall", ctrlupd_ack, 1'b0);
    checkOutput("cu_pu_still_low", phyupd_req, 1'b0);
    applyStimulus(1);
    checkOutput("cu_pu_launch", phyupd_req, 1'b1);
    checkOutput("cu_pu_type", phyupd_type, 2'b11);
    phyupd_ack = 1'b1;
    applyStimulus(4);
    checkOutput("cu_pu_drop", phyupd_req, 1'b0);
    phyupd_ack = 1'b0;
    applyStimulus(1);
    checkOutput("cu_pu_idle", phyupd_busy, 1'b0);

    $display("[TB] ctrlupd stalls behind phyupd_req");
    phyupd_start = 1'b1; phyupd_type_in = 2'b10;
    applyStimulus(1);
    phyupd_start = 1'b0;
    checkOutput("st_pu_req", phyupd_req, 1'b1);
    ctrlupd_req = 1'b1;
    applyStimulus(1);
    checkOutput("st_cu_stall", ctrlupd_ack, 1'b0);
    phyupd_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("st_pu_hold", phyupd_req, 1'b1);
      checkOutput("st_cu_hold", ctrlupd_ack, 1'b0);
    end
    applyStimulus(1);
    checkOutput("st_pu_drop", phyupd_req, 1'b0);
    checkOutput("st_cu_pre", ctrlupd_ack, 1'b0);
    applyStimulus(1);
    checkOutput("st_cu_ack", ctrlupd_ack, 1'b1);
    phyupd_ack = 1'b0; ctrlupd_req = 1'b0;
    applyStimulus(1);
    checkOutput("st_cu_fall", ctrlupd_ack, 1'b0);
    checkOutput("st_pu_idle", phyupd_busy, 1'b0);

    $display("[TB] phyupd without ack");
    phyupd_start = 1'b1; phyupd_type_in = 2'b01;
    applyStimulus(1);
    phyupd_start = 1'b0;
    checkOutput("to_req_rise", phyupd_req, 1'b1);
`ifdef DFI_PHY_RESP_PHYUPD_TIMEOUT_EN
    for (int i = 1; i < int'(TRESP); i++) begin
      applyStimulus(1);
      checkOutput("to_req_wait", phyupd_req, 1'b1);
      checkOutput("to_err_wait", phyupd_err, 1'b0);
    end
    applyStimulus(1);
    checkOutput("to_req_fall", phyupd_req, 1'b0);
    checkOutput("to_err_pulse", phyupd_err, 1'b1);
    applyStimulus(1);
    checkOutput("to_err_end", phyupd_err, 1'b0);
    checkOutput("to_busy_clear", phyupd_busy, 1'b0);
`else
    for (int i = 0; i < 110; i++) begin
      applyStimulus(1);
      checkOutput("nto_req_hold", phyupd_req, 1'b1);
      checkOutput("nto_err_zero", phyupd_err, 1'b0);
    end
    phyupd_ack = 1'b1;
    applyStimulus(4);
    checkOutput("nto_req_fall", phyupd_req, 1'b0);
    phyupd_ack = 1'b0;
    applyStimulus(1);
    checkOutput("nto_busy_clear", phyupd_busy, 1'b0);
`endif

    $display("[TB] reset mid-handshake");
    lp_accept = 2'b11; lp_ctrl_wakeup = 6'h11; lp_ctrl_req = 1'b1;
    phyupd_start = 1'b1; phyupd_type_in = 2'b10;
    applyStimulus(1);
    phyupd_start = 1'b0; phyupd_ack = 1'b1;
    applyStimulus(1);
    checkOutput("mr_lp_ack", lp_ctrl_ack, 1'b1);
    checkOutput("mr_pu_req", phyupd_req, 1'b1);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("mr_lp_ack_zero", lp_ctrl_ack, 1'b0);
    checkOutput("mr_wakeup_zero", lp_ctrl_wakeup_q, 6'h00);
    checkOutput("mr_pu_req_zero", phyupd_req, 1'b0);
    checkOutput("mr_pu_type_zero", phyupd_type, 2'b00);
    checkOutput("mr_pu_busy_zero", phyupd_busy, 1'b0);
    checkOutput("mr_cu_ack_zero", ctrlupd_ack, 1'b0);
    reset = 1'b1; phyupd_ack = 1'b0;
    applyStimulus(1);
    checkOutput("mr_lp_rewait", lp_ctrl_ack, 1'b0);
    checkOutput("mr_pu_idle", phyupd_busy, 1'b0);
    applyStimulus(1);
    checkOutput("mr_lp_reack", lp_ctrl_ack, 1'b1);
    checkOutput("mr_lp_rewake", lp_ctrl_wakeup_q, 6'h11);
    lp_ctrl_req = 1'b0;
    applyStimulus(1);

    $display("[TB] randomized lp traffic");
    reset = 1'b0;
    modelStep(1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
    applyStimulus(1);
    reset = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) lp_ctrl_req = ~lp_ctrl_req;
      if ($urandom_range(0, 5) == 0) lp_data_req = ~lp_data_req;
      lp_accept      = 2'($urandom_range(0, 3));
      lp_ctrl_wakeup = 6'($urandom_range(0, 63));
      lp_data_wakeup = 6'($urandom_range(0, 63));
      reset          = ($urandom_range(0, 79) != 0);
      modelStep(reset, {lp_data_req, lp_ctrl_req}, lp_accept, lp_ctrl_wakeup, lp_data_wakeup);
      applyStimulus(1);
      checkOutput("rnd_ctrl_ack", lp_ctrl_ack, ackx[0]);
      checkOutput("rnd_data_ack", lp_data_ack, ackx[1]);
      checkOutput("rnd_ctrl_wq", lp_ctrl_wakeup_q, wq[0]);
      checkOutput("rnd_data_wq", lp_data_wakeup_q, wq[1]);
    end
    reset = 1'b1; lp_ctrl_req = 1'b0; lp_data_req = 1'b0;
    applyStimulus(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dfi_phy_hs_responder.md
DFI_PHY_HS_RESPONDER -- requirements
Module: dfi_phy_hs_responder

Interface
REQ-001 SHALL have parameter LP_ACK_DLY, default 2: cycles from the first sampled lp_*_req high to lp_*_ack high; legal range 1..255.
REQ-002 SHALL have parameter CTRLUPD_ACK_DLY, default 1: cycles from ctrlupd_req accepted to ctrlupd_ack high; legal range 1..255.
REQ-003 SHALL have parameter PHYUPD_HOLD, default 4: cycles phyupd_req stays high after phyupd_ack is first sampled high.
REQ-004 SHALL have parameter TPHYUPD_RESP, default 16: phyupd ack timeout in cycles.
REQ-005 SHALL have one clock and a synchronous, active-low reset; the ports are named clock and reset.
REQ-006 clock  in  1  rising-edge clock for all state.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 lp_ctrl_req / lp_data_req  in  1  MC low-power requests.
REQ-009 lp_ctrl_wakeup / lp_data_wakeup  in  6  wakeup codes.
REQ-010 lp_accept  in  2  bit0 enables ctrl ack, bit1 enables data ack.
REQ-011 lp_ctrl_ack / lp_data_ack  out  1  low-power acknowledges.
REQ-012 lp_ctrl_wakeup_q / lp_data_wakeup_q  out  6  wakeup code captured at accept.
REQ-013 ctrlupd_req  in  1; ctrlupd_ack  out  1.
REQ-014 phyupd_start  in  1  single-cycle launch pulse; phyupd_type_in  in  2.
REQ-015 phyupd_req  out  1; phyupd_type  out  2; phyupd_ack  in  1.
REQ-016 phyupd_busy  out  1  pending or active phyupd; phyupd_err  out  1  one-cycle timeout pulse.

Function
REQ-017 Each LP channel (ctrl, data) SHALL run an independent FSM with states IDLE, WAIT, ACK, REJ.
REQ-018 From IDLE, req=1 with the lp_accept bit set: go to WAIT, capture wakeup into *_wakeup_q, load the counter with LP_ACK_DLY.
REQ-019 From IDLE, req=1 with the lp_accept bit clear: go to REJ; ack never asserts; return to IDLE when req=0.
REQ-020 The ack SHALL be registered high exactly LP_ACK_DLY cycles after the first cycle req is sampled high (ACK state), and SHALL stay high while req stays high.
REQ-021 If req drops during WAIT: return to IDLE with no ack pulse.
REQ-022 In ACK, req sampled low: ack SHALL fall on the next edge and the FSM returns to IDLE; req cannot re-arm until ack is low.
REQ-023 ctrlupd_req sampled high while phyupd_req=0: ctrlupd_ack SHALL rise CTRLUPD_ACK_DLY cycles later.
REQ-024 While phyupd_req=1, ctrlupd acceptance SHALL stall; the delay count starts in the cycle after phyupd_req falls.
REQ-025 ctrlupd_ack SHALL fall 1 cycle after ctrlupd_req is sampled low; a req dropped before ack produces no ack.
REQ-026 The phyupd FSM SHALL have states IDLE, REQ, HOLD, DROP.
REQ-027 A phyupd_start pulse in IDLE with no pending launch SHALL set pending and latch phyupd_type_in; phyupd_busy SHALL be high while pending or not IDLE.
REQ-028 phyupd_start while busy SHALL be ignored.
REQ-029 IDLE with pending, ctrlupd_req=0 and ctrlupd_ack=0: go to REQ next edge with phyupd_req=1 and phyupd_type driven; pending clears.
REQ-030 Same-cycle ctrlupd_req and pending launch: ctrlupd wins and phyupd waits.
REQ-031 REQ with phyupd_ack=1: go to HOLD for PHYUPD_HOLD cycles, then DROP with phyupd_req=0; DROP exits to IDLE once phyupd_ack=0.
REQ-032 phyupd_type SHALL stay stable from REQ through DROP.
REQ-033 All counters SHALL be 8-bit, load-and-decrement, and saturate at 0 (no wrap).

Reset
REQ-034 While reset=0, at each clock edge all outputs SHALL go to 0, FSMs to IDLE, and pending and counters to 0; this applies mid-handshake too.
REQ-035 After reset release, a req already high SHALL be treated as a new request.

Configuration
REQ-036 Macro DFI_PHY_RESP_PHYUPD_TIMEOUT_EN defined: REQ SHALL count cycles; with no ack after TPHYUPD_RESP cycles, drop phyupd_req, pulse phyupd_err for 1 cycle and go to DROP.
REQ-037 Macro undefined: REQ waits indefinitely, and phyupd_err is tied to 0.

Verification
REQ-038 lp_accept=2'b11, lp_ctrl_req high at cycle 10, wakeup=6'h5 -> lp_ctrl_ack high at cycle 12, wakeup_q=6'h5; req low at 20 -> ack low at 21.
REQ-039 lp_accept[1]=0, lp_data_req high for 20 cycles -> lp_data_ack stays 0; accept then set and req re-raised -> ack after 2 cycles.
REQ-040 phyupd_start at cycle 5 with type 2'b01, ack at cycle 8 -> phyupd_req high cycles 6..11, low at 12; busy clears when ack is 0.
REQ-041 ctrlupd_req rises in the same cycle as a pending phyupd launch -> ctrlupd_ack after 1 cycle; phyupd_req stays low until ctrlupd_ack falls.
REQ-042 With the timeout macro defined, phyupd_ack is never given -> phyupd_req falls 16 cycles after rising, plus one phyupd_err pulse; without the macro, req is held for 100+ cycles.
REQ-043 reset=0 asserted while lp_ctrl_ack=1 and in HOLD -> all outputs 0 the next edge; after release, a held req is re-acked after LP_ACK_DLY.
